// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop toggle monitor.
//   mon_state_t  : monitor FSM state, 2-bit encoding visible on state_o
//   CNT_W_DEF    : default width of the toggle and period counters
//   TIMEOUT_DEF  : default number of cycles without a q transition before stuck
package tff_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    STUCK   = 2'd3
  } mon_state_t;

  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/tff_edge_sampler.sv
// History registers for the toggle monitor.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   arm         : monitor is active this cycle (not IDLE and enabled)
//   t_in, q_in  : t enable and q output of the observed T flip-flop
//   hist_valid  : q_d/t_d hold samples taken while the monitor was active
//   q_edge      : q changed since the previous clock edge
//   exp_edge    : a change of q was expected (t was 1 at the previous edge)
module tff_edge_sampler (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic t_in,
  input  logic q_in,
  output logic hist_valid,
  output logic q_edge,
  output logic exp_edge
);

  logic q_d;
  logic t_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_d        <= 1'b0;
      t_d        <= 1'b0;
      hist_valid <= 1'b0;
    end else begin
      q_d        <= q_in;
      t_d        <= t_in;
      // Becomes valid one cycle after entering ARMED, so the sample taken
      // while idle is never compared. Drops together with the return to IDLE.
      hist_valid <= arm;
    end
  end

  assign q_edge   = hist_valid & (q_in != q_d);
  assign exp_edge = hist_valid & t_d;

endmodule

// File: rtl/tff_toggle_monitor.sv
// Toggle monitor for a T flip-flop stage: checks that q toggles exactly when
// t was 1 at the previous edge, measures the spacing between q transitions,
// reports each spacing on a valid/ready port and flags a stuck output.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   en          : monitoring enable (level)
//   t_in, q_in  : t enable and q output of the observed flop
//   evt_valid/evt_ready/evt_period : period event handshake
//   toggle_cnt  : saturating count of transitions since arm
//   stuck       : no transition for TIMEOUT cycles
//   mismatch    : sticky, q disagreed with t
//   overrun     : sticky, an event was dropped under backpressure
//   state_o     : current FSM state
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | monitoring off, flags and toggle_cnt hold their values
// ARMED   | waiting for the first transition, no event for it
// MEASURE | timing the spacing between transitions, events reported
// STUCK   | no transition for TIMEOUT cycles, next one resumes MEASURE
module tff_toggle_monitor
  import tff_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             t_in,
  input  logic             q_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_period,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             stuck,
  output logic             mismatch,
  output logic             overrun,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  mon_state_t       state;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] pcnt_inc;
  logic [CNT_W-1:0] tcnt_inc;
  logic             arm;
  logic             hist_valid;
  logic             q_edge;
  logic             exp_edge;
  logic             timeout;

  assign arm      = (state != IDLE) && en;
  assign pcnt_inc = (pcnt == CNT_MAX) ? pcnt : pcnt + 1'b1;
  assign tcnt_inc = (toggle_cnt == CNT_MAX) ? toggle_cnt : toggle_cnt + 1'b1;
  assign timeout  = (pcnt == TO_LAST);
  assign state_o  = state;

  tff_edge_sampler u_sampler (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .t_in       (t_in),
    .q_in       (q_in),
    .hist_valid (hist_valid),
    .q_edge     (q_edge),
    .exp_edge   (exp_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      evt_valid  <= 1'b0;
      evt_period <= '0;
      toggle_cnt <= '0;
      stuck      <= 1'b0;
      mismatch   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Completed transfer; a new load below overrides this.
      if (evt_valid && evt_ready)
        evt_valid <= 1'b0;

      if (hist_valid && (q_edge != exp_edge))
        mismatch <= 1'b1;

      if (state == IDLE) begin
        if (en) begin
          state      <= ARMED;
          pcnt       <= '0;
          toggle_cnt <= '0;
          stuck      <= 1'b0;
          mismatch   <= 1'b0;
          overrun    <= 1'b0;
        end
      end else if (!en) begin
        state     <= IDLE;
        evt_valid <= 1'b0;
      end else begin
        if (q_edge)
          toggle_cnt <= tcnt_inc;

        case (state)
          ARMED: begin
            if (q_edge) begin
              state <= MEASURE;
              pcnt  <= '0;
            end else if (timeout) begin
              state <= STUCK;
              stuck <= 1'b1;
            end else begin
              pcnt <= pcnt_inc;
            end
          end

          MEASURE: begin
            // An edge in the timeout cycle still counts as a normal edge.
            if (q_edge) begin
              pcnt <= '0;
              if (!evt_valid || evt_ready) begin
                evt_period <= pcnt_inc;
                evt_valid  <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else if (timeout) begin
              state <= STUCK;
              stuck <= 1'b1;
            end else begin
              pcnt <= pcnt_inc;
            end
          end

          STUCK: begin
            if (q_edge) begin
              state <= MEASURE;
              stuck <= 1'b0;
              pcnt  <= '0;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
